// File: rtl/skid_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : skid_buffer_if
// Brief    : Valid/ready stream bundle for skid_buffer. The upstream (data_in*)
//            and downstream (data_out*) halves are carried together. The
//            environment drives the bundle through 'master' and the buffer
//            uses 'slave'.
// Revision : 1.0 - initial release
// ============================================================================
interface skid_buffer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_in_valid;
  logic                  data_in_ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_ready;

  // Environment side: produces upstream words and downstream acceptance.
  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid
  );

  // Buffer side.
  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid
  );
endinterface
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : skid_buffer
// Brief    : Two-entry fully registered valid/ready stage. main_q drives
//            data_out and skid_q catches the word that arrives while the
//            output is stalled. data_in_ready and data_out_valid are flops
//            derived from the next state, so there is no combinational path
//            from data_out_ready to data_in_ready.
// Revision : 1.0 - initial release
// ============================================================================
module skid_buffer #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  wire logic     clk,
  input  wire logic     rst,    // asynchronous, active-low
  input  wire logic     flush,  // synchronous clear, active-high
  skid_buffer_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t                state_q,     state_d;
  logic [DATA_WIDTH-1:0] main_q,      main_d;
  logic [DATA_WIDTH-1:0] skid_q,      skid_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q,  in_ready_d;

  logic w_in_fire;
  logic w_out_fire;

  // Handshakes use only the registered ready/valid, never the opposite input.
  assign w_in_fire  = bus.data_in_valid & in_ready_q;
  assign w_out_fire = out_valid_q & bus.data_out_ready;

  // Next-state, data steering and registered handshake outputs.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // Buffered words are abandoned; the data registers keep their contents.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (w_in_fire) begin
            main_d  = bus.data_in;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (w_in_fire && w_out_fire) begin
            main_d = bus.data_in;
          end else if (w_in_fire) begin
            skid_d  = bus.data_in;
            state_d = FULL;
          end else if (w_out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // data_in_ready is low here, so only the drain can happen.
          if (w_out_fire) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end

    out_valid_d = (state_d == BUSY) || (state_d == FULL);
    in_ready_d  = (state_d == EMPTY) || (state_d == BUSY);
  end

  // State and data registers; ready stays low until the first edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_q      <= RESET_VALUE;
      skid_q      <= RESET_VALUE;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.data_out       = main_q;
  assign bus.data_out_valid = out_valid_q;
  assign bus.data_in_ready  = in_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_skid_buffer
// Brief    : Self-checking bench for skid_buffer. A reference queue holds the
//            words the buffer should contain, and a negedge monitor compares
//            the DUT outputs against it. Directed checks cover reset, streaming,
//            stall, flush and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_skid_buffer;
  localparam int            DW = 16;
  localparam logic [DW-1:0] RV = 16'hBEEF;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;

  skid_buffer_if #(.DATA_WIDTH(DW)) bus ();

  skid_buffer #(
    .DATA_WIDTH  (DW),
    .RESET_VALUE (RV)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_dut_out = 0;

  // Reference model state: exp_q holds the expected buffer contents, front first.
  logic [DW-1:0] exp_q[$];
  bit            m_rdy     = 1'b0;
  bit            m_rstval  = 1'b1;
  bit            m_in_fire = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: updates at each clock edge or immediately when reset drops.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        exp_q.delete();
        m_rdy     = 1'b0;
        m_rstval  = 1'b1;
        m_in_fire = 1'b0;
      end else begin
        bit inf;
        bit outf;
        inf       = bus.data_in_valid && m_rdy;
        outf      = (exp_q.size() > 0) && bus.data_out_ready;
        m_in_fire = inf && !flush;
        if (flush) begin
          exp_q.delete();
        end else begin
          if (outf) void'(exp_q.pop_front());
          if (inf) begin
            exp_q.push_back(bus.data_in);
            m_rstval = 1'b0;
          end
        end
        m_rdy = (exp_q.size() < 2);
      end
    end
  end

  // Monitor: compares the DUT against the model away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", {15'd0, bus.data_in_ready}, {15'd0, m_rdy});
      chk("out_valid", {15'd0, bus.data_out_valid}, {15'd0, exp_q.size() > 0});
      if (exp_q.size() > 0) begin
        chk("data_out", bus.data_out, exp_q[0]);
      end else if (m_rstval) begin
        chk("data_out_rst", bus.data_out, RV);
      end
      if (bus.data_out_valid && bus.data_out_ready) n_dut_out++;
    end
  end

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit r);
    bus.data_in_valid  = v;
    bus.data_in        = d;
    bus.data_out_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int snap;
    int cyc;
    logic [DW-1:0] w;

    drive(1'b0, '0, 1'b0);
    repeat (2) step();

    // 1: reset release with a word already offered.
    drive(1'b1, 16'h00A5, 1'b1);
    rst = 1'b1;
    #2;
    chk("t1_rdy_pre", {15'd0, bus.data_in_ready}, 16'd0);
    chk("t1_dout_pre", bus.data_out, RV);
    step();
    chk("t1_rdy", {15'd0, bus.data_in_ready}, 16'd1);
    chk("t1_valid0", {15'd0, bus.data_out_valid}, 16'd0);
    chk("t1_dout_rst", bus.data_out, RV);
    step();
    chk("t1_valid1", {15'd0, bus.data_out_valid}, 16'd1);
    chk("t1_dout", bus.data_out, 16'h00A5);
    drive(1'b0, '0, 1'b1);
    repeat (3) step();

    // 2: streaming 0..99 at full rate.
    snap = n_dut_out;
    w    = '0;
    cyc  = 0;
    drive(1'b1, w, 1'b1);
    while (w < 16'd100 && cyc < 200) begin
      step();
      cyc++;
      if (m_in_fire) w = w + 16'd1;
      bus.data_in = w;
    end
    chk("t2_cycles", cyc[DW-1:0], 16'd100);
    drive(1'b0, '0, 1'b1);
    repeat (3) step();
    chk("t2_out_count", 16'(n_dut_out - snap), 16'd100);

    // 3: stall with 1,2 buffered and 3 offered, then release.
    drive(1'b1, 16'd1, 1'b0);
    step();
    bus.data_in = 16'd2;
    step();
    bus.data_in = 16'd3;
    chk("t3_full_rdy", {15'd0, bus.data_in_ready}, 16'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_stall_dout", bus.data_out, 16'd1);
      chk("t3_stall_rdy", {15'd0, bus.data_in_ready}, 16'd0);
    end
    bus.data_out_ready = 1'b1;
    step();
    chk("t3_out2", bus.data_out, 16'd2);
    chk("t3_rdy_back", {15'd0, bus.data_in_ready}, 16'd1);
    step();
    chk("t3_out3", bus.data_out, 16'd3);
    bus.data_in_valid = 1'b0;
    step();
    chk("t3_empty", {15'd0, bus.data_out_valid}, 16'd0);
    repeat (2) step();

    // 4: random valid/ready traffic.
    for (int s = 1; s <= 20; s++) begin
      void'($urandom(s));
      for (int c = 0; c < 500; c++) begin
        drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
        step();
      end
    end
    drive(1'b0, '0, 1'b1);
    repeat (4) step();
    chk("t4_drained", {15'd0, bus.data_out_valid}, 16'd0);

    // 5: flush from FULL while a word is offered and the output is ready.
    drive(1'b1, 16'h0011, 1'b0);
    step();
    bus.data_in = 16'h0022;
    step();
    chk("t5_full", {15'd0, bus.data_in_ready}, 16'd0);
    drive(1'b1, 16'h0033, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, '0, 1'b1);
    chk("t5_valid", {15'd0, bus.data_out_valid}, 16'd0);
    chk("t5_rdy", {15'd0, bus.data_in_ready}, 16'd1);
    snap = n_dut_out;
    repeat (5) step();
    chk("t5_no_emit", 16'(n_dut_out - snap), 16'd0);

    // 6: asynchronous reset while FULL.
    drive(1'b1, 16'h0044, 1'b0);
    step();
    bus.data_in = 16'h0055;
    step();
    chk("t6_full", {15'd0, bus.data_out_valid}, 16'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_valid", {15'd0, bus.data_out_valid}, 16'd0);
    chk("t6_rdy", {15'd0, bus.data_in_ready}, 16'd0);
    chk("t6_dout", bus.data_out, RV);
    drive(1'b1, 16'h0066, 1'b1);
    repeat (2) step();
    rst = 1'b1;
    #2;
    chk("t6_rdy_pre", {15'd0, bus.data_in_ready}, 16'd0);
    step();
    chk("t6_rdy_post", {15'd0, bus.data_in_ready}, 16'd1);
    step();
    chk("t6_dout_post", bus.data_out, 16'h0066);
    drive(1'b0, '0, 1'b1);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/skid_buffer.md
Name: skid_buffer

Overview:
- Two-entry valid/ready pipeline stage that sits directly upstream of the enable-gated pipeline registers.
- Converts a valid/ready stream into a fully registered stream: `data_out`, `data_out_valid` and `data_in_ready` all come from flops.
- Sustains one transfer per cycle with no combinational path from `data_out_ready` to `data_in_ready`.
- Downstream enable-gated registers use `data_out_valid && data_out_ready` as their `clk_en`.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- RESET_VALUE, 0, value of `data_out` and both internal data registers during and after reset (truncated/zero-extended to DATA_WIDTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- flush  input  1  synchronous clear of buffered data, active-high.
- data_in  input  DATA_WIDTH  upstream payload.
- data_in_valid  input  1  upstream payload valid.
- data_in_ready  output  1  buffer can accept; registered.
- data_out  output  DATA_WIDTH  downstream payload; registered.
- data_out_valid  output  1  downstream payload valid; registered.
- data_out_ready  input  1  downstream accepts.

Behaviour:
- Fire definitions:
  - in_fire = data_in_valid && data_in_ready.
  - out_fire = data_out_valid && data_out_ready.
- Internal storage: `main_reg` drives `data_out`; `skid_reg` is the overflow entry. State is one of EMPTY, BUSY, FULL.
- Reset (rst=0, asynchronous):
  - state = EMPTY; main_reg = skid_reg = RESET_VALUE; data_out_valid = 0; data_in_ready = 0.
  - After rst rises, data_in_ready goes to 1 on the first rising clk edge. No transfer is accepted before then.
- Output encoding:
  - EMPTY: data_out_valid=0, data_in_ready=1.
  - BUSY: data_out_valid=1, data_in_ready=1.
  - FULL: data_out_valid=1, data_in_ready=0.
- Transitions (when flush=0):
  - EMPTY, in_fire: main_reg<=data_in, go to BUSY.
  - EMPTY, no in_fire: stay in EMPTY; main_reg holds.
  - BUSY, in_fire && out_fire: main_reg<=data_in, stay in BUSY.
  - BUSY, in_fire && !out_fire: skid_reg<=data_in, go to FULL.
  - BUSY, !in_fire && out_fire: go to EMPTY; main_reg holds its last value.
  - BUSY, neither: hold.
  - FULL, out_fire: main_reg<=skid_reg, go to BUSY.
  - FULL, no out_fire: hold. in_fire is impossible because data_in_ready=0.
- Latency: a word accepted at edge N appears on `data_out` with `data_out_valid=1` after edge N (visible in cycle N+1), provided it is not queued behind `skid_reg`.
- Ordering: strict FIFO; the skid entry is always presented after main_reg. No drop, no duplication.
- Stall stability: while data_out_valid=1 and data_out_ready=0, `data_out` is bit-stable.
- data_in_ready must depend only on state flops, never combinationally on data_out_ready or data_in_valid.
- Flush:
  - flush=1 at an edge: state<=EMPTY, data_out_valid<=0, data_in_ready<=1.
  - Any in_fire or out_fire in that cycle is discarded; the upstream word offered that cycle is lost.
  - main_reg and skid_reg hold.
  - rst has priority over flush.
- Reset mid-operation: all buffered words are discarded immediately, without waiting for a clock edge. The outputs take their reset values while rst=0.
- Invalid state encoding (not reachable): recover to EMPTY on the next edge.
- Area: 2×DATA_WIDTH data flops plus 2-bit state plus the ready/valid flops. No counters wider than 2 bits.

Test Plan:
1. Reset release, data_in_valid=1, data_in=0xA5 held, data_out_ready=1 -> data_in_ready=0 in the first post-reset cycle, then 1. data_out=0xA5 with data_out_valid=1 exactly one cycle after the first in_fire. data_out=RESET_VALUE before that.
2. Streaming 0..99 with data_in_valid=1 and data_out_ready=1 every cycle -> 100 transfers in 100 cycles after a 1-cycle fill. Output sequence 0..99 in order. data_in_ready never drops.
3. Stream 1,2,3 with data_out_ready held low from the cycle 1 is presented -> state FULL with data_out=1 and skid holding 2. data_in_ready=0, data_out stable for 10 cycles. Release ready -> outputs 1, 2, 3 on consecutive cycles and data_in_ready returns to 1.
4. Random data_in_valid and data_out_ready (seeds 1..20, 10k cycles) against a queue scoreboard -> no loss, duplication or reordering. data_out stable whenever valid && !ready. Occupancy never exceeds 2.
5. From FULL (two words held), pulse flush=1 for one cycle with data_in_valid=1 and data_out_ready=1 -> next cycle data_out_valid=0 and data_in_ready=1. Neither held word nor the offered word is ever emitted.
6. Drop rst asynchronously mid-cycle while in FULL -> data_out_valid=0, data_in_ready=0 and data_out=RESET_VALUE before the next clk edge. Recovery follows scenario 1.
